inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Write-side companion of the instruction ROM path: receives a program as a byte stream (from UART/debug bridge) and writes whole instructions into the instruction memory write port.
- Assembles INST_WIDTH/8 bytes per instruction, MSB byte first, writes at sequential addresses starting at 0, and signals done/error.
- Sits between the host byte link and the instruction RAM, so programs can be reloaded without resynthesis.

Parameters:
- INST_WIDTH, 32, instruction width in bits; must be a multiple of 8.
- MAX_NUM_INST, 128, instruction memory depth; defines address width $clog2(MAX_NUM_INST).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE
- num_inst  input  $clog2(MAX_NUM_INST)+1  instruction count for this load; sampled on start
- s_data  input  8  stream byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts byte this cycle
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  $clog2(MAX_NUM_INST)  write address
- wr_data  output  INST_WIDTH  write data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of load (success or error)
- err  output  1  sticky error flag; cleared by the next accepted start
- chk_err  output  1  checksum mismatch, sticky; cleared by the next accepted start (0 when feature disabled)

Behaviour:
- Reset (async, rst_n=0): state IDLE; s_ready, wr_en, busy, done, err, chk_err = 0; wr_addr = 0; wr_data = 0; byte and word counters = 0.
- BYTES = INST_WIDTH/8. Byte handshake = s_valid && s_ready on a rising edge.
- IDLE: s_ready=0. On start:
  - If num_inst == 0 or num_inst > MAX_NUM_INST: err=1, done pulses next cycle, stay IDLE.
  - Otherwise latch the count, clear err/chk_err, set byte_cnt=0, word_cnt=0, next_addr=0, and go to LOAD.
- LOAD: s_ready=1.
  - Each handshake shifts the byte into the assembly register at LSB (left shift by 8), so the first byte lands in bits [INST_WIDTH-1:INST_WIDTH-8].
  - On the handshake where byte_cnt == BYTES-1:
    - The next cycle has wr_en=1 for exactly one cycle, wr_data = assembled word, wr_addr = next_addr.
    - next_addr and word_cnt increment; byte_cnt wraps to 0.
  - Back-to-back bytes are accepted every cycle; bubbles on s_valid are allowed anywhere.
  - When the final word's last byte is accepted: s_ready drops in the same cycle as the final wr_en, and the FSM goes to DONE (or CHECK when the feature is enabled).
- DONE: done=1 for one cycle, then IDLE. busy falls with the return to IDLE.
- wr_addr never wraps; a maximum load writes addresses 0..MAX_NUM_INST-1.
- start while busy: ignored; no effect on counters or flags.
- Reset mid-load: immediate return to IDLE with all outputs at reset values; a partial word is discarded and never written.
- Outside the wr_en cycle, wr_data and wr_addr hold their last values; the memory must qualify on wr_en.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of all accepted program bytes is kept.
  - After the last word, the FSM enters CHECK with s_ready=1 and accepts one extra byte.
  - If that byte != running XOR: chk_err=1 and err=1.
  - The FSM then goes to DONE. Written words are not rolled back.
- Disabled: no CHECK state, no XOR register, chk_err tied to 0.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately. start with num_inst=2 and bytes 12 34 56 78 9A BC DE F0 -> wr_en at addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0; done pulses once; err=0.
- Stalled stream: same load with s_valid toggling every other cycle -> identical writes; wr_en count == 2; s_ready low after final byte.
- Bad counts: num_inst=0 -> err=1, done pulse, no wr_en. num_inst=129 (MAX=128) -> same. A subsequent valid start clears err.
- Full depth: num_inst=128 with word k = k -> last write addr 127 data 127; no write beyond 127; done once.
- Reset mid-word: assert rst_n=0 after 2 of 4 bytes of word 3 -> no write for word 3; busy=0. A new load restarts at addr 0.
- Checksum (macro defined): 1 word 01 02 03 04 then checksum 0x04 -> chk_err=0. The same load with checksum 0x05 -> chk_err=1, err=1, done pulse.

Source files
------------

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream program loader into the instruction memory write port
// Optional trailing XOR checksum byte: define INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int INST_WIDTH   = 32,
  parameter int MAX_NUM_INST = 128
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_NUM_INST):0]   num_inst,
  input  logic [7:0]                      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            wr_en,
  output logic [$clog2(MAX_NUM_INST)-1:0] wr_addr,
  output logic [INST_WIDTH-1:0]           wr_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            chk_err
);

  localparam int AW    = $clog2(MAX_NUM_INST);
  localparam int BYTES = INST_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [AW:0]    MAX_CNT   = (AW+1)'(MAX_NUM_INST);
  localparam logic [AW:0]    ONE       = (AW+1)'(1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_CHECK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  logic [AW:0]           num_q;
  logic [AW:0]           word_cnt_q;
  logic [BCW-1:0]        byte_cnt_q;
  logic                  wr_en_q;
  logic [AW-1:0]         wr_addr_q;
  logic [INST_WIDTH-1:0] wr_data_q;
  logic                  err_q;
  logic                  bad_done_q;
  logic                  chk_err_q;
  logic [INST_WIDTH-1:0] word_full;
  logic                  count_ok;
  logic                  load_hs;
  logic                  last_byte;
  logic                  last_word;

  assign count_ok  = (num_inst != '0) && (num_inst <= MAX_CNT);
  assign load_hs   = (state_q == S_LOAD) && s_valid;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_word = (word_cnt_q == (num_q - ONE));

  // Assembly register holds the bytes already received for the current word.
  if (BYTES > 1) begin : g_asm
    logic [INST_WIDTH-9:0] asm_q;
    assign word_full = {asm_q, s_data};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        asm_q <= '0;
      end else if (load_hs) begin
        asm_q <= word_full[INST_WIDTH-9:0];
      end
    end
  end else begin : g_noasm
    assign word_full = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && count_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && last_byte && last_word) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        s_ready = 1'b1;
        if (s_valid) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      bad_done_q <= 1'b0;
      chk_err_q  <= 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      wr_en_q    <= 1'b0;
      bad_done_q <= 1'b0;
      if ((state_q == S_IDLE) && start) begin
        if (!count_ok) begin
          err_q      <= 1'b1;
          bad_done_q <= 1'b1;
        end else begin
          num_q      <= num_inst;
          err_q      <= 1'b0;
          chk_err_q  <= 1'b0;
          byte_cnt_q <= '0;
          word_cnt_q <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          xor_q      <= '0;
`endif
        end
      end
      if (load_hs) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        xor_q <= xor_q ^ s_data;
`endif
        if (last_byte) begin
          byte_cnt_q <= '0;
          wr_en_q    <= 1'b1;
          wr_data_q  <= word_full;
          wr_addr_q  <= word_cnt_q[AW-1:0];
          word_cnt_q <= word_cnt_q + ONE;
        end else begin
          byte_cnt_q <= byte_cnt_q + BCW'(1);
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      if ((state_q == S_CHECK) && s_valid && (s_data != xor_q)) begin
        chk_err_q <= 1'b1;
        err_q     <= 1'b1;
      end
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) || bad_done_q;
  assign err     = err_q;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - self-checking bench for inst_mem_loader
module tb_inst_mem_loader;
  localparam int W     = 32;
  localparam int MAXN  = 128;
  localparam int AW    = 7;
  localparam int BYTES = W / 8;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  localparam bit CHKEN = 1'b1;
`else
  localparam bit CHKEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_inst = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, wr_en, busy, done, err, chk_err;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  always #5 clk = ~clk;

  inst_mem_loader #(.INST_WIDTH(W), .MAX_NUM_INST(MAXN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inst(num_inst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .chk_err(chk_err)
  );

  int nvec = 0;
  int nfail = 0;

  logic [AW-1:0] wa_q[$];
  logic [W-1:0]  wd_q[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int num;
    int mode;
    int pat;
    bit chk_bad;
    bit exp_err;
    int exp_nwr;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] tx_q[$];
  logic [W-1:0] exp_w[$];
  logic [7:0] plan_bytes[8];

  task automatic build(input vec_t v);
    int x;
    tx_q.delete();
    exp_w.delete();
    for (int k = 0; k < v.num && k <= MAXN; k++) begin
      for (int j = 0; j < BYTES; j++) begin
        case (v.pat)
          0: tx_q.push_back(plan_bytes[(k * BYTES + j) % 8]);
          1: tx_q.push_back(8'((k >> (8 * (BYTES - 1 - j))) % 256));
          3: tx_q.push_back(8'(j + 1));
          default: tx_q.push_back(8'($urandom));
        endcase
      end
    end
    // Reference: big-endian byte grouping, computed arithmetically.
    for (int k = 0; k * BYTES < tx_q.size(); k++) begin
      longint acc = 0;
      for (int j = 0; j < BYTES; j++) acc = acc * 256 + longint'(tx_q[k * BYTES + j]);
      exp_w.push_back(W'(acc));
    end
    x = 0;
    for (int i = 0; i < tx_q.size(); i++) x = x ^ int'(tx_q[i]);
    if (CHKEN) tx_q.push_back(v.chk_bad ? 8'(x ^ 1) : 8'(x));
  endtask

  task automatic send_bytes(input int mode, input int nmax, input bit noise);
    int i = 0;
    int cyc = 0;
    while (i < nmax && cyc < 4000) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 1);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = s_valid ? tx_q[i] : 8'($urandom);
      if (noise) begin
        start    = ($urandom_range(0, 3) == 0);
        num_inst = (AW+1)'($urandom);
      end
      @(negedge clk);
      if (s_valid && s_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("bytes_accepted", 64'(i), 64'(nmax));
  endtask

  task automatic run_vector(input vec_t v, input int id);
    int  base_w, base_d, nwr, c;
    bit  cnt_bad;
    string nm;
    nm      = $sformatf("v%0d", id);
    cnt_bad = (v.num == 0) || (v.num > MAXN);
    build(v);
    base_w = wa_q.size();
    base_d = done_cnt;
    @(posedge clk); #1;
    start    = 1'b1;
    num_inst = (AW+1)'(v.num);
    @(posedge clk); #1;
    start    = 1'b0;
    num_inst = (AW+1)'($urandom);
    if (!cnt_bad) begin
      @(negedge clk);
      check({nm, "_err_cleared"}, 64'(err), 64'(0));
      check({nm, "_busy"}, 64'(busy), 64'(1));
      @(posedge clk); #1;
      send_bytes(v.mode, tx_q.size(), v.mode == 2);
      @(negedge clk);
      check({nm, "_s_ready_low"}, 64'(s_ready), 64'(0));
    end
    c = 0;
    @(negedge clk);
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_idle"}, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    nwr = wa_q.size() - base_w;
    check({nm, "_nwr"}, 64'(nwr), 64'(v.exp_nwr));
    for (int k = 0; k < nwr && k < exp_w.size(); k++)
      check($sformatf("%s_wr%0d", nm, k), {32'(wa_q[base_w + k]), 32'(wd_q[base_w + k])},
            {32'(k), 32'(exp_w[k])});
    check({nm, "_done_cnt"}, 64'(done_cnt - base_d), 64'(1));
    check({nm, "_err"}, 64'(err), 64'(v.exp_err || (CHKEN && v.chk_bad && !cnt_bad)));
    if (!cnt_bad) check({nm, "_chk_err"}, 64'(chk_err), 64'(CHKEN && v.chk_bad));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_outs"}, {57'(0), s_ready, wr_en, busy, done, err, chk_err, 1'b0}, 64'(0));
    check({nm, "_addr_data"}, {25'(0), wr_addr, wr_data}, 64'(0));
  endtask

  initial begin
    plan_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    //            num  mode pat chk_bad exp_err exp_nwr
    tbl[0]  = '{2,   0, 0, 1'b0, 1'b0, 2};
    tbl[1]  = '{2,   1, 0, 1'b0, 1'b0, 2};
    tbl[2]  = '{0,   0, 2, 1'b0, 1'b1, 0};
    tbl[3]  = '{129, 0, 2, 1'b0, 1'b1, 0};
    tbl[4]  = '{1,   0, 2, 1'b0, 1'b0, 1};
    tbl[5]  = '{128, 0, 1, 1'b0, 1'b0, 128};
    for (int i = 6; i < 10; i++) begin
      int n = $urandom_range(1, 8);
      tbl[i] = '{n, 2, 2, 1'b0, 1'b0, n};
    end
    tbl[10] = '{1, 0, 3, 1'b0, 1'b0, 1};
    tbl[11] = '{1, 2, 3, 1'b1, 1'b0, 1};

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vector(tbl[i], i);

    // Reset two bytes into word 3: words 0..2 written, partial word dropped.
    begin
      vec_t v;
      int base_w;
      v = '{4, 0, 2, 1'b0, 1'b0, 4};
      build(v);
      base_w = wa_q.size();
      @(posedge clk); #1;
      start    = 1'b1;
      num_inst = (AW+1)'(4);
      @(posedge clk); #1;
      start    = 1'b0;
      send_bytes(0, 3 * BYTES + 2, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_nwr", 64'(wa_q.size() - base_w), 64'(3));
      check("midreset_busy", 64'(busy), 64'(0));
    end

    run_vector(tbl[0], 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
